axis_pkt_gen: RTL and testbench
===============================

Name: axis_pkt_gen

Overview:
AXI-Stream packet transmitter. It accepts length commands on a valid/ready command port and emits one packet of that many beats per command on a registered AXI-Stream master port. Each beat carries a deterministic tag pattern. The block is used as the traffic source feeding register slices and stream sinks in bring-up and loopback benches on the virtualization shell.

Parameters:
DATA_WIDTH, 64, output stream data width in bits; legal range is 32 or more.
LEN_WIDTH, 16, width of the packet length field in beats; legal range is 1 to 16.

Ports:
clk  input  1  clock; all interfaces are synchronous to it.
resetn  input  1  active-low reset; asynchronous assert, synchronous deassert handled externally.
cmd_len  input  LEN_WIDTH  packet length in beats.
cmd_valid  input  1  command valid.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
out_data  output  DATA_WIDTH  stream data.
out_last  output  1  marks the final beat of a packet.
out_valid  output  1  stream valid.
out_ready  input  1  stream backpressure.
busy  output  1  high while a packet is in progress.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - Beat counter = 0, packet id counter = 0.
  - cmd_ready reads 1 once resetn=1.
  - Asserting reset mid-packet drops out_valid immediately, with no clock edge needed. The partial packet is abandoned; no last beat is sent.
- FSM states: IDLE, SEND.
- Command acceptance:
  - cmd_ready = (state==IDLE) || (out_valid && out_ready && out_last). Combinational, so back-to-back packets have no gap.
  - cmd_ready never depends on cmd_valid.
- Accept with cmd_len != 0 (edge N):
  - Latch len, state=SEND, beat index=0.
  - out_valid=1 from N+1 with beat 0. Latency from command accept to first beat is 1 cycle.
- Accept with cmd_len == 0: command consumed, no beats emitted, packet id unchanged. The FSM goes to or stays in IDLE. If this happens on a last-beat handshake, the FSM returns to IDLE.
- Beat data format:
  - out_data[15:0] = beat index, zero-extended from LEN_WIDTH.
  - out_data[31:16] = packet id.
  - Remaining upper bits = 0.
- out_last = (beat index == len-1). A len of 1 gives a single beat with out_last=1.
- Handshake rules:
  - out_data, out_last and out_valid are all registered outputs.
  - While out_valid && !out_ready, they hold stable for any number of cycles. AXI-S rule: valid never drops without a handshake.
  - On out_valid && out_ready, non-last beat: beat index +1 and the next beat is presented on the following cycle. Sustained throughput is 1 beat/cycle when out_ready=1.
  - On a last-beat handshake: packet id +1, wrapping 0xFFFF to 0x0000.
    - With a new nonzero command accepted in the same cycle: stay in SEND, beat index=0, new len. out_valid stays 1.
    - Otherwise: state=IDLE, out_valid=0, out_last=0.
- busy = (state==SEND).
- Width rules:
  - Beat index is LEN_WIDTH bits.
  - Maximum packet is 2^LEN_WIDTH−1 beats; no overflow is possible since index < len.
  - Packet id is always 16 bits.
- cmd_len is sampled only on the accepting edge. Changes at other times are ignored.

Test Plan:
1. Reset then single command, cmd_len=3, out_ready=1 -> out_valid high on 3 consecutive cycles starting 1 cycle after accept. out_data = 0x0000_0000, 0x0000_0001, 0x0000_0002. out_last only on the third beat. busy falls the cycle after the last beat.
2. Back-to-back: cmd_valid held with lens 2 then 1, out_ready=1 -> 3 contiguous beats with no idle cycle. Data = 0x0000_0000, 0x0000_0001 (last), 0x0001_0000 (last). cmd_ready pulses on the last-beat cycle.
3. Backpressure: cmd_len=4, out_ready toggled 1,0,0,1,0,1,1 -> each beat stays stable while out_ready=0. Exactly 4 handshakes occur, with indices 0..3 in order. out_valid never drops mid-packet.
4. Zero length: cmd_len=0, then cmd_len=1 -> the first command produces no beats. The second emits data 0x0000_0000 with last (packet id not incremented by the zero-length command).
5. Reset mid-packet: cmd_len=10, deassert resetn after beat 4 handshake, between clock edges -> out_valid=0 and busy=0 immediately. After release, cmd_ready=1, and the next packet starts with packet id 0 and index 0.
6. Packet id wrap: issue 65537 single-beat commands -> packet 65536 carries id 0xFFFF and packet 65537 carries id 0x0000.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// axis_pkt_gen
//   AXI-Stream packet transmitter. Each accepted length command produces one
//   packet of that many beats on a registered AXI-Stream master port. Every
//   beat carries {packet id, beat index} in its low 32 bits. The remaining
//   upper bits are zero.
//
// Ports
//   clk        clock for all interfaces
//   resetn     asynchronous active-low reset
//   cmd_len    packet length in beats (0 = consume command, emit nothing)
//   cmd_valid  command valid
//   cmd_ready  command ready (combinational, independent of cmd_valid)
//   out_data   stream data  [15:0] beat index, [31:16] packet id
//   out_last   final beat of the packet
//   out_valid  stream valid
//   out_ready  stream backpressure
//   busy       high while a packet is in progress
// ---------------------------------------------------------------------------
module axis_pkt_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [LEN_WIDTH-1:0]   len_r;
   logic [LEN_WIDTH-1:0]   len_nxt_s;
   logic [LEN_WIDTH-1:0]   idx_r;
   logic [LEN_WIDTH-1:0]   idx_nxt_s;
   logic [15:0]            pkt_id_r;
   logic [15:0]            pkt_id_nxt_s;
   logic                   out_valid_r;
   logic                   out_last_r;
   logic [DATA_WIDTH-1:0]  out_data_r;

   logic                   hs_s;
   logic                   last_hs_s;
   logic                   cmd_ready_s;
   logic                   accept_s;
   logic                   cmd_nz_s;
   logic                   send_nxt_s;
   logic                   last_nxt_s;

   // Assemble one beat word: index in [15:0], packet id in [31:16], rest zero.
   function automatic logic [DATA_WIDTH-1:0] beat_word(
      input logic [15:0]          id,
      input logic [LEN_WIDTH-1:0] idx
   );
      logic [DATA_WIDTH-1:0] w;
      w        = {DATA_WIDTH{1'b0}};
      w[15:0]  = 16'(idx);
      w[31:16] = id;
      return w;
   endfunction

   assign hs_s      = out_valid_r && out_ready;
   assign last_hs_s = hs_s && out_last_r;
   // Ready also on the last-beat handshake so consecutive packets have no gap.
   assign cmd_ready_s = (state_r == ST_IDLE) || last_hs_s;
   assign accept_s    = cmd_valid && cmd_ready_s;
   assign cmd_nz_s    = (cmd_len != {LEN_WIDTH{1'b0}});

   // Next-state, length, beat index and packet id.
   always_comb begin
      state_nxt_s  = state_r;
      len_nxt_s    = len_r;
      idx_nxt_s    = idx_r;
      pkt_id_nxt_s = pkt_id_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && cmd_nz_s) begin
               state_nxt_s = ST_SEND;
               len_nxt_s   = cmd_len;
               idx_nxt_s   = {LEN_WIDTH{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_hs_s) begin
               pkt_id_nxt_s = pkt_id_r + 16'd1;
               // A zero-length command accepted here is simply consumed.
               if (accept_s && cmd_nz_s) begin
                  state_nxt_s = ST_SEND;
                  len_nxt_s   = cmd_len;
                  idx_nxt_s   = {LEN_WIDTH{1'b0}};
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else if (hs_s) begin
               idx_nxt_s = idx_r + LEN_WIDTH'(1);
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign send_nxt_s = (state_nxt_s == ST_SEND);
   assign last_nxt_s = send_nxt_s && (idx_nxt_s == (len_nxt_s - LEN_WIDTH'(1)));

   // State and output registers; outputs are loaded from next-state values
   // so a stalled beat reloads identical contents every cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         len_r       <= {LEN_WIDTH{1'b0}};
         idx_r       <= {LEN_WIDTH{1'b0}};
         pkt_id_r    <= 16'd0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         len_r       <= len_nxt_s;
         idx_r       <= idx_nxt_s;
         pkt_id_r    <= pkt_id_nxt_s;
         out_valid_r <= send_nxt_s;
         out_last_r  <= last_nxt_s;
         if (send_nxt_s) begin
            out_data_r <= beat_word(pkt_id_nxt_s, idx_nxt_s);
         end else begin
            out_data_r <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   assign cmd_ready = cmd_ready_s;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = out_data_r;
   assign busy      = (state_r == ST_SEND);

endmodule

// File: tb/tb_axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_gen
//   Self-checking bench for axis_pkt_gen. A transaction-level model keeps the
//   queue of beats still owed on the stream; every negedge the DUT outputs are
//   compared against it. Directed tests pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_axis_pkt_gen;

   localparam int DW = 64;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic [LW-1:0] cmd_len;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cmd_len   (cmd_len),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- model: beats still owed on the stream ----------------
   typedef struct packed {
      logic [15:0] id;
      logic [15:0] idx;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] next_id;

   // Beats observed on the stream (recorded the half-cycle before handshake).
   logic [63:0] got_data[$];
   logic        got_last[$];
   int          got_cyc[$];

   always @(posedge clk) cyc++;

   // Model update on each edge: pop on handshake, then enqueue an accepted packet.
   always @(posedge clk or negedge resetn) begin
      bit hs;
      bit rdy;
      if (!resetn) begin
         exp_q.delete();
         next_id = 16'd0;
      end else begin
         hs  = (exp_q.size() > 0) && out_ready;
         rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && hs);
         if (hs) void'(exp_q.pop_front());
         if (cmd_valid && rdy && (cmd_len != 16'd0)) begin
            for (int i = 0; i < int'(cmd_len); i++) begin
               exp_q.push_back('{id: next_id, idx: 16'(i), last: (i == int'(cmd_len) - 1)});
            end
            next_id = next_id + 16'd1;
         end
      end
   end

   // Compare process: every negedge while out of reset.
   always @(negedge clk) begin
      beat_t b;
      bit    ev;
      if (resetn) begin
         ev = (exp_q.size() > 0);
         check("out_valid", 64'(out_valid), 64'(ev));
         check("busy", 64'(busy), 64'(ev));
         check("cmd_ready", 64'(cmd_ready),
               64'((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready)));
         if (ev) begin
            b = exp_q[0];
            check("out_data", out_data, {32'h0, b.id, b.idx});
            check("out_last", 64'(out_last), 64'(b.last));
         end
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_cyc.push_back(cyc + 1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_log();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      resetn = 1'b0;
      @(posedge clk); #3;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   // Present a command and hold it until accepted; returns the accepting edge.
   task automatic issue(input logic [15:0] len, output int acc_edge);
      bit ok;
      ok        = 1'b0;
      acc_edge  = -1;
      cmd_len   = len;
      cmd_valid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok       = 1'b1;
            acc_edge = cyc + 1;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!ok) check("cmd_accept_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_q.size() == 0) done = 1'b1;
      end
      if (!done) check("idle_timeout", 64'(done), 64'd1);
      @(posedge clk); #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int acc;
      int acc2;
      bit ok;
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_len   = 16'd0;
      out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      #5 resetn = 1'b1;
      #1 check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;

      // 1: single packet of 3
      clear_log();
      issue(16'd3, acc);
      wait_idle(50);
      check("t1_count", 64'(got_data.size()), 64'd3);
      if (got_data.size() == 3) begin
         check("t1_d0", got_data[0], 64'h0000_0000);
         check("t1_d1", got_data[1], 64'h0000_0001);
         check("t1_d2", got_data[2], 64'h0000_0002);
         check("t1_l0", 64'(got_last[0]), 64'd0);
         check("t1_l1", 64'(got_last[1]), 64'd0);
         check("t1_l2", 64'(got_last[2]), 64'd1);
         // Beat 0 is presented the cycle after accept, handshaking one edge later.
         check("t1_lat", 64'(got_cyc[0]), 64'(acc + 1));
         check("t1_c2", 64'(got_cyc[2]), 64'(acc + 3));
      end

      // 2: back-to-back lens 2 then 1
      do_reset();
      clear_log();
      issue(16'd2, acc);
      issue(16'd1, acc2);
      wait_idle(50);
      check("t2_count", 64'(got_data.size()), 64'd3);
      check("t2_acc_gap", 64'(acc2), 64'(acc + 2));
      if (got_data.size() == 3) begin
         check("t2_d0", got_data[0], 64'h0000_0000);
         check("t2_d1", got_data[1], 64'h0000_0001);
         check("t2_d2", got_data[2], 64'h0001_0000);
         check("t2_l1", 64'(got_last[1]), 64'd1);
         check("t2_l2", 64'(got_last[2]), 64'd1);
         check("t2_contig", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
      end

      // 3: backpressure 1,0,0,1,0,1,1 over a 4-beat packet
      do_reset();
      clear_log();
      issue(16'd4, acc);
      begin
         logic [6:0] pat;
         pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1
         for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      wait_idle(50);
      check("t3_count", 64'(got_data.size()), 64'd4);
      if (got_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("t3_idx", got_data[i], 64'(i));
            check("t3_last", 64'(got_last[i]), 64'(i == 3));
         end
      end

      // 4: zero length then length 1
      do_reset();
      clear_log();
      issue(16'd0, acc);
      issue(16'd1, acc);
      wait_idle(50);
      check("t4_count", 64'(got_data.size()), 64'd1);
      if (got_data.size() == 1) begin
         check("t4_d0", got_data[0], 64'h0000_0000);
         check("t4_l0", 64'(got_last[0]), 64'd1);
      end

      // 5: reset in the middle of a 10-beat packet
      do_reset();
      clear_log();
      issue(16'd10, acc);
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(posedge clk); #1;
         if (got_data.size() >= 5) ok = 1'b1;
      end
      check("t5_reach_beat4", 64'(ok), 64'd1);
      @(posedge clk); #3;      // beat 4 handshake has happened
      resetn = 1'b0;
      #1;
      check("t5_valid_async", 64'(out_valid), 64'd0);
      check("t5_busy_async", 64'(busy), 64'd0);
      @(posedge clk); #3;
      resetn = 1'b1;
      #1 check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      clear_log();
      issue(16'd1, acc);
      wait_idle(50);
      check("t5_count", 64'(got_data.size()), 64'd1);
      if (got_data.size() == 1) begin
         check("t5_d0", got_data[0], 64'h0000_0000);
         check("t5_l0", 64'(got_last[0]), 64'd1);
      end

      // 6: packet id wrap over 65537 single-beat packets
      do_reset();
      clear_log();
      for (int i = 0; i < 65537; i++) begin
         issue(16'd1, acc);
      end
      wait_idle(50);
      check("t6_count", 64'(got_data.size()), 64'd65537);
      if (got_data.size() == 65537) begin
         check("t6_first", got_data[0], 64'h0000_0000);
         check("t6_ffff", got_data[65535], 64'hFFFF_0000);
         check("t6_wrap", got_data[65536], 64'h0000_0000);
         check("t6_wrap_last", 64'(got_last[65536]), 64'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
